// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the instruction memory.
// It takes a byte stream over a valid/ready handshake and builds big-endian
// 32-bit words from it. Each word is written to consecutive word addresses.
// A trailing XOR checksum is checked before the core is let out of reset.
//
// Stream format: N[15:8], N[7:0], 4*N data bytes, then the XOR of all
// preceding bytes.
//
// Ports:
//   clk, rst             clock (rising edge), async active-low reset
//   in_data/in_valid     byte source; in_ready marks acceptance
//   start                re-arm request, honoured only in DONE or ERROR
//   mem_we/addr/wdata    registered instruction-memory write port
//   cpu_hold             1 keeps the core in reset
//   busy, done, error    load status
//
// state  | meaning
// -------+-----------------------------------------------
// LEN_HI | waiting for word count high byte
// LEN_LO | waiting for word count low byte, range check
// DATA   | assembling words and writing them to memory
// CSUM   | waiting for checksum byte
// DONE   | program loaded and verified, core released
// ERROR  | bad length or checksum, core held
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        start,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] idx_q;
    logic [1:0]  byte_cnt;
    logic [31:0] word_q;
    logic [7:0]  csum_q;

    logic        xfer;
    logic [15:0] len_next;
    logic [31:0] word_next;
    logic [7:0]  csum_next;

    assign xfer      = in_valid && in_ready;
    assign len_next  = {len_q[15:8], in_data};
    assign word_next = {word_q[23:0], in_data};
    assign csum_next = csum_q ^ in_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LEN_HI;
            in_ready  <= 1'b1;
            busy      <= 1'b1;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE_ADDR;
            mem_wdata <= 32'h0;
            len_q     <= 16'h0;
            idx_q     <= 16'h0;
            byte_cnt  <= 2'd0;
            word_q    <= 32'h0;
            csum_q    <= 8'h0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                S_LEN_HI: begin
                    if (xfer) begin
                        len_q[15:8] <= in_data;
                        csum_q      <= csum_next;
                        state       <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (xfer) begin
                        len_q[7:0] <= in_data;
                        csum_q     <= csum_next;
                        if ({1'b0, len_next} > MAX_N) begin
                            state    <= S_ERROR;
                            in_ready <= 1'b0;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                        end else if (len_next == 16'h0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        csum_q   <= csum_next;
                        word_q   <= word_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // Address wraps modulo 2^32 by construction.
                            mem_we    <= 1'b1;
                            mem_wdata <= word_next;
                            mem_addr  <= BASE_ADDR + {14'h0, idx_q, 2'b00};
                            idx_q     <= idx_q + 16'd1;
                            if (idx_q == len_q - 16'd1) begin
                                state <= S_CSUM;
                            end
                        end
                    end
                end
                S_CSUM: begin
                    if (xfer) begin
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        if (in_data == csum_q) begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (start) begin
                        state    <= S_LEN_HI;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        error    <= 1'b0;
                        mem_addr <= BASE_ADDR;
                        len_q    <= 16'h0;
                        idx_q    <= 16'h0;
                        byte_cnt <= 2'd0;
                        word_q   <= 32'h0;
                        csum_q   <= 8'h0;
                    end
                end
                default: begin
                    state    <= S_ERROR;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b1;
                    done     <= 1'b0;
                    error    <= 1'b1;
                end
            endcase
        end
    end

endmodule
